// File: rtl/axis_row_producer_pkg.sv
// ---------------------------------------------------------------------------
// axis_row_producer_pkg
//
// Shared definitions for the AXI-Stream row producer and for any receive-side
// logic that must agree with it on row geometry.
//
//   state_e            : producer FSM state encoding (IDLE=0, SEND=1, GAP=2)
//   DEFAULT_ROW_BEATS  : default beats per row; the receive-side row counter
//                        uses the same constant so both ends agree
//   SEQ_WIDTH          : width of the sequence word replicated across TDATA
//   GAP_WIDTH          : width of the inter-row gap counter / input
// ---------------------------------------------------------------------------
package axis_row_producer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_ROW_BEATS = 66;
    localparam int unsigned SEQ_WIDTH         = 32;
    localparam int unsigned GAP_WIDTH         = 16;

endpackage

// File: rtl/axis_row_producer.sv
// ---------------------------------------------------------------------------
// axis_row_producer
//
// AXI-Stream traffic source. A start pulse launches a run of row_count rows,
// each ROW_BEATS beats long, separated by gap_cycles idle cycles. The payload
// is a 32-bit sequence word (0 at the start of every run, +1 per transferred
// beat) replicated across TDATA. TLAST marks the last beat of each row.
//
// Ports:
//   clk          in   single rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   begin a run; only honoured while idle
//   row_count    in   rows to send, latched on an accepted start
//   gap_cycles   in   idle cycles between rows, latched on an accepted start
//   busy         out  high while a run is in progress
//   row_sent     out  one-cycle strobe after each row's TLAST transfer
//   done         out  one-cycle strobe at the end of a run
//   AXIS_TDATA   out  replicated sequence word
//   AXIS_TVALID  out  beat valid (registered, independent of TREADY)
//   AXIS_TLAST   out  final beat of a row
//   AXIS_TREADY  in   downstream ready
// ---------------------------------------------------------------------------
module axis_row_producer
    import axis_row_producer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ROW_BEATS   = DEFAULT_ROW_BEATS,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] row_count,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    output logic                   busy,
    output logic                   row_sent,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  AXIS_TDATA,
    output logic                   AXIS_TVALID,
    output logic                   AXIS_TLAST,
    input  logic                   AXIS_TREADY
);

    localparam int unsigned BEAT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int unsigned LANES  = DATA_WIDTH / SEQ_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ROW_BEATS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [BEAT_W-1:0]      beat_q,      beat_d;
    logic [COUNT_WIDTH-1:0] rows_q,      rows_d;
    logic [SEQ_WIDTH-1:0]   seq_q,       seq_d;
    logic [GAP_WIDTH-1:0]   gap_len_q,   gap_len_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q,   gap_cnt_d;
    logic                   tvalid_q,    tvalid_d;
    logic                   tlast_q,     tlast_d;
    logic                   busy_q,      busy_d;
    logic                   row_sent_q,  row_sent_d;
    logic                   done_q,      done_d;

    logic                   xfer;

    assign xfer = tvalid_q && AXIS_TREADY;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            rows_q     <= '0;
            seq_q      <= '0;
            gap_len_q  <= '0;
            gap_cnt_q  <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            row_sent_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rows_q     <= rows_d;
            seq_q      <= seq_d;
            gap_len_q  <= gap_len_d;
            gap_cnt_q  <= gap_cnt_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            row_sent_q <= row_sent_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rows_d     = rows_q;
        seq_d      = seq_q;
        gap_len_d  = gap_len_q;
        gap_cnt_d  = gap_cnt_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        busy_d     = busy_q;
        row_sent_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d    = row_count;
                    gap_len_d = gap_cycles;
                    seq_d     = '0;
                    beat_d    = '0;
                    tlast_d   = 1'b0;
                    if (row_count != '0) begin
                        state_d  = ST_SEND;
                        tvalid_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        // Empty run: report completion without emitting beats.
                        done_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (xfer) begin
                    seq_d = seq_q + SEQ_WIDTH'(1);
                    if (tlast_q) begin
                        row_sent_d = 1'b1;
                        rows_d     = rows_q - COUNT_WIDTH'(1);
                        beat_d     = '0;
                        tlast_d    = 1'b0;
                        if (rows_q == COUNT_WIDTH'(1)) begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else if (gap_len_q != '0) begin
                            state_d   = ST_GAP;
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_len_q;
                        end
                        // Zero gap: stay in SEND with TVALID held so beat 0
                        // of the next row follows without a bubble.
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        tlast_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
                    end
                end
            end

            ST_GAP: begin
                // gap_cnt_q counts the idle cycles still to show; leaving on
                // the value 1 makes TVALID low for exactly gap_len_q cycles.
                if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    state_d   = ST_SEND;
                    tvalid_d  = 1'b1;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy        = busy_q;
    assign row_sent    = row_sent_q;
    assign done        = done_q;
    assign AXIS_TVALID = tvalid_q;
    assign AXIS_TLAST  = tlast_q;

    // The sequence register only advances on a transfer, so TDATA is
    // inherently stable while a beat is stalled.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign AXIS_TDATA[i*SEQ_WIDTH +: SEQ_WIDTH] = seq_q;
    end

endmodule
